// File: rtl/div_sequencer.sv
// Goldschmidt division sequencer: issues ITERS D/N multiply pairs, captures the quotient.
// Quotient valid 2*ITERS+3 cycles after acceptance (1 for D==0); holds q until out_ready.
module div_sequencer #(
  parameter int WIDTH = 16,
  parameter int ITERS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] N_in,
  input  logic [WIDTH-1:0] D_in,
  input  logic [WIDTH-1:0] IA_in,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] IA,
  output logic             kSelect,
  output logic             ndSelect,
  input  logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             div0
);

  localparam int IW = $clog2(ITERS + 1);
  localparam logic [IW-1:0] ITERS_L = IW'(ITERS);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_D,
    ISSUE_N,
    DRAIN,
    CAPTURE,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   i;
  logic [IW-1:0]   i_inc;
  logic            accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign i_inc     = i + IW'(1);

  always_comb begin
    state_nxt = state;
    kSelect   = 1'b0;
    ndSelect  = 1'b1;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (D_in == '0) ? DONE : ISSUE_D;
        end
      end
      ISSUE_D: begin
        ndSelect  = 1'b0;
        // k comes from IA only on the first pass; later passes derive it from result
        kSelect   = (i == '0);
        state_nxt = ISSUE_N;
      end
      ISSUE_N: begin
        state_nxt = (i_inc < ITERS_L) ? ISSUE_D : DRAIN;
      end
      DRAIN: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      i     <= '0;
      N     <= '0;
      D     <= '0;
      IA    <= '0;
      q     <= '0;
      div0  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        N  <= N_in;
        D  <= D_in;
        IA <= IA_in;
        i  <= '0;
        if (D_in == '0) begin
          q    <= '1;
          div0 <= 1'b1;
        end
      end
      if (state == ISSUE_N) begin
        i <= i_inc;
      end
      // result for the last N issue arrives exactly in the CAPTURE cycle
      if (state == CAPTURE) begin
        q    <= result;
        div0 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: schedule, hold, divide-by-zero, reset abort,
// back-to-back throughput, and an ITERS=1 instance.
module tb_div_sequencer;

  logic        clk;
  logic        reset;

  logic        in_valid, in_ready, ks, nd, out_valid, out_ready, div0;
  logic [15:0] N_in, D_in, IA_in, N, D, IA, result, q;

  logic        in_valid_1, in_ready_1, ks_1, nd_1, out_valid_1, out_ready_1, div0_1;
  logic [15:0] N_in_1, D_in_1, IA_in_1, N_1, D_1, IA_1, result_1, q_1;

  int total;
  int bad;

  div_sequencer #(.WIDTH(16), .ITERS(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .N_in(N_in), .D_in(D_in), .IA_in(IA_in),
    .N(N), .D(D), .IA(IA),
    .kSelect(ks), .ndSelect(nd),
    .result(result),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div0(div0)
  );

  div_sequencer #(.WIDTH(16), .ITERS(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_1), .in_ready(in_ready_1),
    .N_in(N_in_1), .D_in(D_in_1), .IA_in(IA_in_1),
    .N(N_1), .D(D_1), .IA(IA_1),
    .kSelect(ks_1), .ndSelect(nd_1),
    .result(result_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1),
    .q(q_1), .div0(div0_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({ks, nd} !== 2'b01) begin bad++; $display("FAIL reset_sel got=%b exp=01", {ks, nd}); end
    total++; if ({q, N, D, IA} !== 64'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {q, N, D, IA}); end
    total++; if (div0 !== 1'b0) begin bad++; $display("FAIL reset_div0 got=%b exp=0", div0); end
    #3 reset = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got=%b%b exp=10", in_ready, out_valid);
    end
  endtask

  // Full ITERS=3 division with expected select pattern per cycle 1..8, then a held output.
  task automatic run_div(input logic [15:0] n, input logic [15:0] d, input logic [15:0] ia,
                         input logic [15:0] res, input string tag);
    logic [7:0] ks_tab;
    logic [7:0] nd_tab;
    ks_tab = 8'b0000_0001;
    nd_tab = 8'b1110_1010;
    N_in = n; D_in = d; IA_in = ia; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++; if (ks !== ks_tab[c-1] || nd !== nd_tab[c-1]) begin
        bad++; $display("FAIL %s_sel cycle=%0d got=%b%b exp=%b%b", tag, c, ks, nd, ks_tab[c-1], nd_tab[c-1]);
      end
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL %s_busy cycle=%0d got ov=%b ir=%b exp ov=0 ir=0", tag, c, out_valid, in_ready);
      end
      if (c == 1) begin
        total++; if ({N, D, IA} !== {n, d, ia}) begin
          bad++; $display("FAIL %s_latch got=%h exp=%h", tag, {N, D, IA}, {n, d, ia});
        end
      end
      result = (c == 8) ? res : 16'hBEEF;
      step();
    end
    result = 16'hBEEF;
    total++; if (out_valid !== 1'b1 || q !== res || div0 !== 1'b0) begin
      bad++; $display("FAIL %s_out cycle=9 got ov=%b q=%h d0=%b exp ov=1 q=%h d0=0", tag, out_valid, q, div0, res);
    end
    // stalled consumer, with a competing request that must be ignored
    out_ready = 1'b0;
    in_valid = 1'b1; N_in = 16'hAAAA; D_in = 16'h5555; IA_in = 16'h1111;
    for (int h = 0; h < 5; h++) begin
      step();
      total++; if (out_valid !== 1'b1 || q !== res || {N, D, IA} !== {n, d, ia}) begin
        bad++; $display("FAIL %s_hold h=%0d got ov=%b q=%h N=%h exp ov=1 q=%h N=%h", tag, h, out_valid, q, N, res, n);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s_handshake got ov=%b ir=%b exp ov=0 ir=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_schedule();
    run_div(16'h3000, 16'h6000, 16'h5555, 16'h1234, "sched");
  endtask

  task automatic test_div_zero();
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dz_early_ready got ov=%b exp=0", out_valid); end
    out_ready = 1'b0;
    N_in = 16'h0042; D_in = 16'h0000; IA_in = 16'h7777; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || q !== 16'hFFFF || div0 !== 1'b1) begin
      bad++; $display("FAIL dz_out got ov=%b q=%h d0=%b exp ov=1 q=ffff d0=1", out_valid, q, div0);
    end
    total++; if (nd !== 1'b1 || ks !== 1'b0) begin bad++; $display("FAIL dz_sel got=%b%b exp=01", ks, nd); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || nd !== 1'b1) begin
      bad++; $display("FAIL dz_return got ir=%b ov=%b nd=%b exp ir=1 ov=0 nd=1", in_ready, out_valid, nd);
    end
  endtask

  task automatic test_reset_mid();
    N_in = 16'h0100; D_in = 16'h0200; IA_in = 16'h0300; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || {ks, nd} !== 2'b01) begin
      bad++; $display("FAIL mid_reset_ctl got ir=%b ov=%b sel=%b%b exp ir=1 ov=0 sel=01", in_ready, out_valid, ks, nd);
    end
    total++; if ({q, N, D, IA} !== 64'h0 || div0 !== 1'b0) begin
      bad++; $display("FAIL mid_reset_regs got=%h d0=%b exp=0 d0=0", {q, N, D, IA}, div0);
    end
    #2 reset = 1'b1;
    run_div(16'h3000, 16'h6000, 16'h5555, 16'h0F0F, "after_rst");
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    logic [15:0] exp_n;
    logic have;
    have = 1'b0;
    exp_n = 16'h0;
    D_in = 16'h4000; IA_in = 16'h2222; N_in = 16'h0500;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (have) begin
        total++; if (N !== exp_n || D !== 16'h4000 || IA !== 16'h2222) begin
          bad++; $display("FAIL b2b_operands cycle=%0d got N=%h D=%h IA=%h exp N=%h D=4000 IA=2222", c, N, D, IA, exp_n);
        end
      end
      N_in = N_in + 16'h1;
      if (in_ready) begin
        exp_n = N_in;
        have = 1'b1;
        acc_cyc.push_back(c);
      end
      step();
    end
    in_valid = 1'b0;
    total++; if (acc_cyc.size() != 4) begin
      bad++; $display("FAIL b2b_count got=%0d exp=4", acc_cyc.size());
    end
    for (int k = 1; k < acc_cyc.size(); k++) begin
      total++; if (acc_cyc[k] - acc_cyc[k-1] != 10) begin
        bad++; $display("FAIL b2b_spacing k=%0d got=%0d exp=10", k, acc_cyc[k] - acc_cyc[k-1]);
      end
    end
    for (int w = 0; w < 12; w++) step();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain got ir=%b exp=1", in_ready); end
  endtask

  task automatic test_iters1();
    logic [3:0] ks_tab;
    logic [3:0] nd_tab;
    ks_tab = 4'b0001;
    nd_tab = 4'b1110;
    N_in_1 = 16'h1000; D_in_1 = 16'h2000; IA_in_1 = 16'h3000; in_valid_1 = 1'b1;
    step();
    in_valid_1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++; if (ks_1 !== ks_tab[c-1] || nd_1 !== nd_tab[c-1] || out_valid_1 !== 1'b0) begin
        bad++; $display("FAIL it1_sel cycle=%0d got ks=%b nd=%b ov=%b exp ks=%b nd=%b ov=0",
                        c, ks_1, nd_1, out_valid_1, ks_tab[c-1], nd_tab[c-1]);
      end
      result_1 = (c == 4) ? 16'h0777 : 16'hBEEF;
      step();
    end
    result_1 = 16'hBEEF;
    total++; if (out_valid_1 !== 1'b1 || q_1 !== 16'h0777 || div0_1 !== 1'b0) begin
      bad++; $display("FAIL it1_out cycle=5 got ov=%b q=%h d0=%b exp ov=1 q=0777 d0=0", out_valid_1, q_1, div0_1);
    end
    out_ready_1 = 1'b1;
    step();
    out_ready_1 = 1'b0;
    total++; if (in_ready_1 !== 1'b1) begin bad++; $display("FAIL it1_return got ir=%b exp=1", in_ready_1); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    in_valid = 1'b0; out_ready = 1'b0; N_in = '0; D_in = '0; IA_in = '0; result = 16'hBEEF;
    in_valid_1 = 1'b0; out_ready_1 = 1'b0; N_in_1 = '0; D_in_1 = '0; IA_in_1 = '0; result_1 = 16'hBEEF;
    test_reset();
    test_schedule();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    test_iters1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand, initial-approximation and quotient width.
REQ-002 Parameter ITERS, default 3, legal 1..15: Goldschmidt iterations per division.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces the reset state immediately, independent of clk.
REQ-005 in_valid  input  1  N_in, D_in and IA_in are valid.
REQ-006 in_ready  output  1  block accepts a new division.
REQ-007 N_in, D_in, IA_in  input  WIDTH each  dividend, divisor, initial reciprocal approximation.
REQ-008 N, D, IA  output  WIDTH each  latched operands driven to the multiply datapath.
REQ-009 kSelect  output  1  1 = datapath k factor loads from IA; 0 = k is generated from the previous result.
REQ-010 ndSelect  output  1  1 = datapath multiplies N; 0 = datapath multiplies D and loads k.
REQ-011 result  input  WIDTH  rounded product returned by the datapath, 2 cycles after the matching issue cycle.
REQ-012 out_valid  output  1  q and div0 are valid.
REQ-013 out_ready  input  1  consumer accepts q.
REQ-014 q  output  WIDTH  captured quotient.
REQ-015 div0  output  1  divisor was zero.

Function
REQ-016 States: IDLE, ISSUE_D, ISSUE_N, DRAIN, CAPTURE, DONE; iteration counter i is $clog2(ITERS+1) bits wide.
REQ-017 IDLE: in_ready=1. in_valid&in_ready latches N_in, D_in, IA_in into N, D, IA, clears i, and moves to ISSUE_D, or to DONE with q=all-ones and div0=1 when D_in==0.
REQ-018 ISSUE_D: ndSelect=0, kSelect=(i==0); next state ISSUE_N.
REQ-019 ISSUE_N: ndSelect=1, kSelect=0; i increments. Next state is ISSUE_D if the incremented i<ITERS, else DRAIN.
REQ-020 DRAIN: ndSelect=1, kSelect=0, one cycle; next state CAPTURE.
REQ-021 CAPTURE: q<=result, div0<=0, ndSelect=1, kSelect=0; next state DONE.
REQ-022 In all states other than ISSUE_D, ISSUE_N, DRAIN and CAPTURE, ndSelect=1 and kSelect=0, so the datapath k register stays frozen.
REQ-023 Schedule: with acceptance at edge 0, ISSUE_D occupies cycle 1+2i and ISSUE_N occupies cycle 2+2i for i=0..ITERS-1.
REQ-024 CAPTURE occupies cycle 2*ITERS+2, and out_valid rises in cycle 2*ITERS+3 (9 for ITERS=3).
REQ-025 DONE: out_valid=1, and q and div0 hold stable until out_valid&out_ready; on that handshake out_valid drops and the state returns to IDLE.
REQ-026 Back-to-back: the earliest next acceptance is the cycle after the output handshake; in_ready is 0 in every state except IDLE.
REQ-027 in_valid outside IDLE is ignored, and N, D and IA change only on acceptance.
REQ-028 out_ready while out_valid=0 has no effect.
REQ-029 q, div0, N, D and IA are registered outputs.
REQ-030 in_ready, out_valid, kSelect and ndSelect are decoded from the state register only; none has a combinational path from any input.

Reset
REQ-031 While reset=0: state=IDLE, i=0, in_ready=1, out_valid=0, q=0, div0=0, N=D=IA=0, kSelect=0, ndSelect=1.
REQ-032 Reset asserted mid-division or in DONE abandons the operation with no output handshake; the first acceptance after reset release behaves as from power-up.

Verification
REQ-033 ITERS=3, accept N_in=0x3000, D_in=0x6000, IA_in=0x5555 at edge 0 -> (kSelect,ndSelect) over cycles 1..6 = (1,0),(0,1),(0,0),(0,1),(0,0),(0,1); out_valid rises in cycle 9.
REQ-034 Datapath model drives result=0x1234 only in cycle 8 -> q=0x1234 and div0=0 in cycle 9; out_ready held low 5 cycles -> q stays 0x1234 and out_valid stays 1 throughout.
REQ-035 D_in=0x0000 accepted -> next cycle out_valid=1, q=0xFFFF, div0=1; no ndSelect=0 cycle occurs.
REQ-036 reset pulsed low in cycle 4 of a division -> all outputs take REQ-031 values within that cycle; the next division after release shows the REQ-033 timing exactly.
REQ-037 in_valid held high continuously with out_ready=1 -> one acceptance every 2*ITERS+4 cycles; N, D and IA never change between acceptances.
REQ-038 ITERS=1 -> exactly one ISSUE_D/ISSUE_N pair, CAPTURE in cycle 4, out_valid in cycle 5.
